// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/exec/halt program-counter sequencer with call link register and retired-instruction counter
module pc_sequencer #(
  parameter int PC_WIDTH = 32,
  parameter int OFFSET_WIDTH = 26,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fetch_ack,
  input  logic                    valid_jump,
  input  logic [OFFSET_WIDTH-1:0] jump_offset,
  input  logic                    is_call,
  input  logic                    is_return,
  input  logic                    halt,
  input  logic                    resume,
  output logic [PC_WIDTH-1:0]     pc,
  output logic                    fetch_req,
  output logic [PC_WIDTH-1:0]     link_addr,
  output logic [1:0]              state,
  output logic [CNT_WIDTH-1:0]    retired
);
  typedef enum logic [1:0] {FETCH = 2'b00, EXEC = 2'b01, HALT = 2'b10, ILLEGAL = 2'b11} state_t;
  state_t cur, nxt;
  logic [PC_WIDTH-1:0] pc_nxt, link_nxt, pc_inc, disp;
  logic [CNT_WIDTH-1:0] retired_nxt;
  assign pc_inc = pc + PC_WIDTH'(4);
  assign disp = {{(PC_WIDTH-OFFSET_WIDTH){jump_offset[OFFSET_WIDTH-1]}}, jump_offset} << 2;
  assign fetch_req = cur == FETCH;
  assign state = cur;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cur <= FETCH;
      pc <= RESET_PC;
      link_addr <= '0;
      retired <= '0;
    end else begin
      cur <= nxt;
      pc <= pc_nxt;
      link_addr <= link_nxt;
      retired <= retired_nxt;
    end
  always_comb begin
    nxt = cur;
    pc_nxt = pc;
    link_nxt = link_addr;
    retired_nxt = retired;
    case (cur)
      FETCH: nxt = fetch_ack ? EXEC : FETCH;
      EXEC: begin
        retired_nxt = retired + CNT_WIDTH'(1);
        nxt = halt ? HALT : FETCH;
        pc_nxt = halt ? pc : is_return ? link_addr : valid_jump ? pc_inc + disp : pc_inc;
        link_nxt = (!halt && !is_return && valid_jump && is_call) ? pc_inc : link_addr;
      end
      HALT: begin
        nxt = resume ? FETCH : HALT;
        pc_nxt = resume ? pc_inc : pc;
      end
      default: nxt = FETCH;
    endcase
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: randomized and directed check of pc_sequencer against an instruction-level model
module tb_pc_sequencer;
  logic clk = 0, rst = 0, fetch_ack = 0, valid_jump = 0, is_call = 0, is_return = 0, halt = 0, resume = 0;
  logic [25:0] jump_offset = '0;
  logic [31:0] pc, link_addr;
  logic fetch_req;
  logic [1:0] state;
  logic [7:0] retired;
  int n_cmp = 0, n_bad = 0;
  pc_sequencer #(.PC_WIDTH(32), .OFFSET_WIDTH(26), .RESET_PC(32'h0), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .fetch_ack(fetch_ack), .valid_jump(valid_jump), .jump_offset(jump_offset),
    .is_call(is_call), .is_return(is_return), .halt(halt), .resume(resume), .pc(pc),
    .fetch_req(fetch_req), .link_addr(link_addr), .state(state), .retired(retired));
  always #5 clk = ~clk;
  logic [31:0] m_pc, m_link;
  logic [1:0] m_state;
  logic [7:0] m_ret;
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_pc <= 0;
      m_link <= 0;
      m_state <= 0;
      m_ret <= 0;
    end else if (m_state == 0) begin
      if (fetch_ack) m_state <= 1;
    end else if (m_state == 1) begin
      m_ret <= m_ret + 8'd1;
      if (halt) m_state <= 2;
      else begin
        m_state <= 0;
        if (is_return) m_pc <= m_link;
        else if (valid_jump) begin
          m_pc <= m_pc + 32'd4 + 32'($signed(jump_offset)) * 32'd4;
          if (is_call) m_link <= m_pc + 32'd4;
        end else m_pc <= m_pc + 32'd4;
      end
    end else if (m_state == 2 && resume) begin
      m_pc <= m_pc + 32'd4;
      m_state <= 0;
    end
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (!rst) begin
      chk("pc", pc, m_pc);
      chk("link", link_addr, m_link);
      chk("state", 32'(state), 32'(m_state));
      chk("fetch_req", 32'(fetch_req), 32'(m_state == 0));
      chk("retired", 32'(retired), 32'(m_ret));
    end
  task automatic junk();
    valid_jump = 1'($urandom);
    jump_offset = 26'($urandom);
    is_call = 1'($urandom);
    is_return = 1'($urandom);
    halt = 1'($urandom);
  endtask
  task automatic instr(int dly, bit vj, logic [25:0] off, bit call, bit ret, bit hlt);
    repeat (dly) begin
      fetch_ack = 0;
      resume = 1'($urandom);
      junk();
      @(negedge clk);
    end
    fetch_ack = 1;
    resume = 1'($urandom);
    junk();
    @(negedge clk);
    fetch_ack = 1'($urandom);
    resume = 1'($urandom);
    valid_jump = vj;
    jump_offset = off;
    is_call = call;
    is_return = ret;
    halt = hlt;
    @(negedge clk);
    fetch_ack = 0;
    resume = 0;
    junk();
  endtask
  task automatic halt_wait(int n);
    repeat (n) begin
      fetch_ack = 1'($urandom);
      resume = 0;
      junk();
      @(negedge clk);
    end
    resume = 1;
    @(negedge clk);
    resume = 0;
  endtask
  task automatic do_reset();
    #2 rst = 1;
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_retired", 32'(retired), 32'h0);
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_link", link_addr, 32'h0);
    @(negedge clk);
    rst = 0;
  endtask
  initial begin
    #1 rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("init_fetch_req", 32'(fetch_req), 32'h1);
    repeat (3) instr(0, 0, 0, 0, 0, 0);
    chk("seq_pc", pc, 32'hC);
    chk("seq_retired", 32'(retired), 32'd3);
    instr(1, 0, 0, 0, 0, 0);
    instr(0, 1, -26'sd2, 0, 0, 0);
    chk("jump_back", pc, 32'h0C);
    instr(0, 0, 0, 1, 0, 0);
    chk("call_no_jump", link_addr, 32'h0);
    instr(0, 1, 26'd3, 0, 0, 0);
    chk("jump_fwd", pc, 32'h20);
    instr(2, 1, 26'd7, 0, 0, 0);
    chk("to_40", pc, 32'h40);
    instr(0, 1, 26'h10, 1, 0, 0);
    chk("call_link", link_addr, 32'h44);
    chk("call_pc", pc, 32'h84);
    instr(0, 0, 0, 1, 1, 0);
    chk("ret_pc", pc, 32'h44);
    chk("ret_link", link_addr, 32'h44);
    instr(0, 1, -26'sd16, 0, 0, 0);
    chk("to_8", pc, 32'h8);
    instr(0, 1, 26'd5, 0, 0, 1);
    chk("halt_state", 32'(state), 32'h2);
    halt_wait(10);
    chk("resume_pc", pc, 32'hC);
    chk("resume_state", 32'(state), 32'h0);
    fetch_ack = 0;
    repeat (5) @(negedge clk);
    chk("stall_pc", pc, 32'hC);
    chk("stall_state", 32'(state), 32'h0);
    do_reset();
    instr(0, 1, -26'sd2, 0, 0, 0);
    chk("wrap_setup", pc, 32'hFFFFFFFC);
    instr(0, 0, 0, 0, 0, 0);
    chk("pc_wrap", pc, 32'h0);
    repeat (253) instr(0, 0, 0, 0, 0, 0);
    chk("ret_max", 32'(retired), 32'hFF);
    instr(0, 0, 0, 0, 0, 0);
    chk("ret_wrap", 32'(retired), 32'h0);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) do_reset();
      else begin
        bit h = $urandom_range(0, 9) == 0;
        instr(int'($urandom_range(0, 3)), 1'($urandom), 26'($urandom), 1'($urandom),
              $urandom_range(0, 3) == 0, h);
        if (h) halt_wait(int'($urandom_range(0, 4)));
      end
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
